// File: rtl/gcd_pkg.sv
// Shared register map, field positions and sequencer state encoding for the GCD sequencer.
package gcd_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_LIMIT  = 3'd2;
    localparam logic [2:0] ADDR_CYCLE  = 3'd3;
    localparam logic [2:0] ADDR_RUNS   = 3'd4;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_ABORT_BIT = 1;
    localparam int CTRL_IRQEN_BIT = 2;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_TMO_BIT   = 2;
    localparam int STAT_ABT_BIT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } seqState_t;

    // Byte-lane merge; laneEnN is active-low like the bus byte enables.
    function automatic logic [31:0] mergeLanes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  laneEnN);
        logic [31:0] result;
        result = oldVal;
        for (int i = 0; i < 4; i++) begin
            if (!laneEnN[i]) result[i*8 +: 8] = newVal[i*8 +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/gcd_sequencer_if.sv
// SRAM-style register bus between a host and the GCD sequencer.
interface gcd_sequencer_if;
    logic        SRAM_CEn;
    logic        SRAM_WEn;
    logic [31:0] SRAM_ADDR;
    logic [63:0] SRAM_WDATA;
    logic [7:0]  SRAM_WBEn;
    logic [63:0] SRAM_RDATA;

    modport master (output SRAM_CEn, SRAM_WEn, SRAM_ADDR, SRAM_WDATA, SRAM_WBEn,
                    input  SRAM_RDATA);
    modport slave  (input  SRAM_CEn, SRAM_WEn, SRAM_ADDR, SRAM_WDATA, SRAM_WBEn,
                    output SRAM_RDATA);
endinterface

// File: rtl/gcd_seq_regs.sv
// Register file and bus decode: CTRL/STATUS/LIMIT storage, read mux and registered IRQ.
module gcd_seq_regs
    import gcd_pkg::*;
#(
    parameter int          CNT_W           = 32,
    parameter logic [31:0] TIMEOUT_DEFAULT = 32'h0010_0000
)(
    input  logic             CLK,
    input  logic             RESETn,
    gcd_sequencer_if.slave   bus,
    input  logic             i_busy,
    input  logic             i_setDone,
    input  logic             i_setTmo,
    input  logic             i_setAbt,
    input  logic             i_clrStatus,
    input  logic [CNT_W-1:0] i_cycleCount,
    input  logic [15:0]      i_runCount,
    output logic             o_startWr,
    output logic             o_abortWr,
    output logic [CNT_W-1:0] o_limit,
    output logic             o_irq
);

    logic             w_wr, w_rd;
    logic [2:0]       w_addr;
    logic             w_ctrlWr, w_statusWr, w_limitWr;
    logic [63:0]      w_rdMux;
    logic             w_unusedBits;
    logic             r_irqEn, r_doneSt, r_tmoSt, r_abtSt, r_irq;
    logic [CNT_W-1:0] r_limit;
    logic [63:0]      r_rdata;

    assign w_wr       = !bus.SRAM_CEn && !bus.SRAM_WEn;
    assign w_rd       = !bus.SRAM_CEn &&  bus.SRAM_WEn;
    assign w_addr     = bus.SRAM_ADDR[5:3];
    assign w_ctrlWr   = w_wr && (w_addr == ADDR_CTRL)   && !bus.SRAM_WBEn[0];
    assign w_statusWr = w_wr && (w_addr == ADDR_STATUS) && !bus.SRAM_WBEn[0];
    assign w_limitWr  = w_wr && (w_addr == ADDR_LIMIT);

    assign o_startWr  = w_ctrlWr && bus.SRAM_WDATA[CTRL_START_BIT];
    assign o_abortWr  = w_ctrlWr && bus.SRAM_WDATA[CTRL_ABORT_BIT];
    assign o_limit    = r_limit;
    assign o_irq      = r_irq;
    assign bus.SRAM_RDATA = r_rdata;

    assign w_unusedBits = ^{bus.SRAM_ADDR[31:6], bus.SRAM_ADDR[2:0],
                            bus.SRAM_WDATA[63:32], bus.SRAM_WBEn[7:4]};

    always_comb begin
        w_rdMux = '0;
        case (w_addr)
            ADDR_CTRL:   w_rdMux[CTRL_IRQEN_BIT] = r_irqEn;
            ADDR_STATUS: begin
                w_rdMux[STAT_BUSY_BIT] = i_busy;
                w_rdMux[STAT_DONE_BIT] = r_doneSt;
                w_rdMux[STAT_TMO_BIT]  = r_tmoSt;
                w_rdMux[STAT_ABT_BIT]  = r_abtSt;
            end
            ADDR_LIMIT:  w_rdMux = 64'(r_limit);
            ADDR_CYCLE:  w_rdMux = 64'(i_cycleCount);
            ADDR_RUNS:   w_rdMux = 64'(i_runCount);
            default:     w_rdMux = '0;
        endcase
    end

    // Hardware status sets take precedence over both W1C writes and the launch-time clear.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_irqEn  <= 1'b0;
            r_doneSt <= 1'b0;
            r_tmoSt  <= 1'b0;
            r_abtSt  <= 1'b0;
            r_irq    <= 1'b0;
            r_limit  <= CNT_W'(TIMEOUT_DEFAULT);
            r_rdata  <= '0;
        end else begin
            if (w_ctrlWr) r_irqEn <= bus.SRAM_WDATA[CTRL_IRQEN_BIT];
            if (w_limitWr)
                r_limit <= CNT_W'(mergeLanes(32'(r_limit), bus.SRAM_WDATA[31:0],
                                             bus.SRAM_WBEn[3:0]));

            if (i_setDone) r_doneSt <= 1'b1;
            else if (i_clrStatus || (w_statusWr && bus.SRAM_WDATA[STAT_DONE_BIT])) r_doneSt <= 1'b0;
            if (i_setTmo) r_tmoSt <= 1'b1;
            else if (i_clrStatus || (w_statusWr && bus.SRAM_WDATA[STAT_TMO_BIT])) r_tmoSt <= 1'b0;
            if (i_setAbt) r_abtSt <= 1'b1;
            else if (i_clrStatus || (w_statusWr && bus.SRAM_WDATA[STAT_ABT_BIT])) r_abtSt <= 1'b0;

            r_irq <= r_irqEn && (r_doneSt || r_tmoSt || r_abtSt);
            if (w_rd) r_rdata <= w_rdMux;
        end
    end

endmodule

// File: rtl/gcd_sequencer.sv
// GCD job sequencer: launch/run/drain FSM with cycle and run counters around gcd_seq_regs.
module gcd_sequencer
    import gcd_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_DEFAULT = 32'h0010_0000,
    parameter int          CNT_W           = 32
)(
    input  logic           CLK,
    input  logic           RESETn,
    gcd_sequencer_if.slave bus,
    output logic           GCD_START,
    output logic           GCD_ABORT,
    input  logic           DONE,
    output logic           IRQ
);

    seqState_t        r_state, w_nextState;
    logic [CNT_W-1:0] r_cycleCount, w_limit;
    logic [15:0]      r_runCount;
    logic             r_gcdAbort;
    logic             w_startWr, w_abortWr, w_busy, w_timeoutHit;
    logic             w_launch, w_setDone, w_setTmo, w_setAbt;

    gcd_seq_regs #(
        .CNT_W           (CNT_W),
        .TIMEOUT_DEFAULT (TIMEOUT_DEFAULT)
    ) u_regs (
        .CLK          (CLK),
        .RESETn       (RESETn),
        .bus          (bus),
        .i_busy       (w_busy),
        .i_setDone    (w_setDone),
        .i_setTmo     (w_setTmo),
        .i_setAbt     (w_setAbt),
        .i_clrStatus  (w_launch),
        .i_cycleCount (r_cycleCount),
        .i_runCount   (r_runCount),
        .o_startWr    (w_startWr),
        .o_abortWr    (w_abortWr),
        .o_limit      (w_limit),
        .o_irq        (IRQ)
    );

    assign w_busy       = (r_state != ST_IDLE);
    assign w_timeoutHit = (w_limit != '0) && (r_cycleCount == w_limit - CNT_W'(1));
    assign GCD_START    = (r_state == ST_LAUNCH);
    assign GCD_ABORT    = r_gcdAbort;

    // DONE outranks timeout, which outranks a host ABORT, when several land together.
    always_comb begin
        w_nextState = r_state;
        w_launch    = 1'b0;
        w_setDone   = 1'b0;
        w_setTmo    = 1'b0;
        w_setAbt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_startWr) begin
                    w_nextState = ST_LAUNCH;
                    w_launch    = 1'b1;
                end
            end
            ST_LAUNCH: w_nextState = ST_RUN;
            ST_RUN: begin
                if (DONE) begin
                    w_nextState = ST_DRAIN;
                    w_setDone   = 1'b1;
                end else if (w_timeoutHit) begin
                    w_nextState = ST_DRAIN;
                    w_setTmo    = 1'b1;
                end else if (w_abortWr) begin
                    w_nextState = ST_DRAIN;
                    w_setAbt    = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!DONE) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) r_state <= ST_IDLE;
        else         r_state <= w_nextState;
    end

    // The cycle counter freezes at LIMIT-1 on a timeout so it reports the limit reached.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_cycleCount <= '0;
            r_runCount   <= '0;
            r_gcdAbort   <= 1'b0;
        end else begin
            r_gcdAbort <= w_setTmo || w_setAbt;
            if (w_launch)
                r_cycleCount <= '0;
            else if ((r_state == ST_RUN) && !w_setTmo && (r_cycleCount != '1))
                r_cycleCount <= r_cycleCount + CNT_W'(1);
            if (w_setDone) r_runCount <= r_runCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_gcd_sequencer.sv
// Directed bench for gcd_sequencer: hand-computed vectors through one checking task.
module tb_gcd_sequencer;

    logic CLK = 1'b0;
    logic RESETn;
    logic DONE;
    logic GCD_START, GCD_ABORT, IRQ;
    int   vectorCount = 0;
    int   failCount   = 0;
    int   startPulses = 0;
    int   abortPulses = 0;
    logic [63:0] rdVal;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h08;
    localparam logic [31:0] A_LIMIT  = 32'h10;
    localparam logic [31:0] A_CYCLE  = 32'h18;
    localparam logic [31:0] A_RUNS   = 32'h20;
    localparam logic [31:0] A_UNMAP  = 32'h38;

    gcd_sequencer_if busIf();

    gcd_sequencer dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .bus       (busIf),
        .GCD_START (GCD_START),
        .GCD_ABORT (GCD_ABORT),
        .DONE      (DONE),
        .IRQ       (IRQ)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (GCD_START) startPulses <= startPulses + 1;
        if (GCD_ABORT) abortPulses <= abortPulses + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] wbEn);
        busIf.SRAM_CEn   = 1'b0;
        busIf.SRAM_WEn   = 1'b0;
        busIf.SRAM_ADDR  = addr;
        busIf.SRAM_WDATA = data;
        busIf.SRAM_WBEn  = wbEn;
        tick(1);
        busIf.SRAM_CEn   = 1'b1;
        busIf.SRAM_WEn   = 1'b1;
        busIf.SRAM_WBEn  = 8'hFF;
    endtask

    task automatic busRead(input logic [31:0] addr, output logic [63:0] data);
        busIf.SRAM_CEn  = 1'b0;
        busIf.SRAM_WEn  = 1'b1;
        busIf.SRAM_ADDR = addr;
        tick(1);
        busIf.SRAM_CEn  = 1'b1;
        data = busIf.SRAM_RDATA;
    endtask

    task automatic applyStimulus();
        // Reset values
        RESETn = 1'b0;
        DONE   = 1'b0;
        busIf.SRAM_CEn   = 1'b1;
        busIf.SRAM_WEn   = 1'b1;
        busIf.SRAM_ADDR  = '0;
        busIf.SRAM_WDATA = '0;
        busIf.SRAM_WBEn  = 8'hFF;
        tick(3);
        checkOutput("rst_start", 64'(GCD_START), 64'h0);
        checkOutput("rst_abort", 64'(GCD_ABORT), 64'h0);
        checkOutput("rst_irq",   64'(IRQ), 64'h0);
        checkOutput("rst_rdata", busIf.SRAM_RDATA, 64'h0);
        RESETn = 1'b1;
        tick(1);
        busRead(A_LIMIT, rdVal);  checkOutput("rst_limit", rdVal, 64'h0010_0000);
        busRead(A_STATUS, rdVal); checkOutput("rst_status", rdVal, 64'h0);

        // Normal job, DONE 10 cycles after launch
        busWrite(A_CTRL, 64'h5, 8'hFE);
        checkOutput("job1_start_hi", 64'(GCD_START), 64'h1);
        tick(1);
        checkOutput("job1_start_lo", 64'(GCD_START), 64'h0);
        tick(9);
        DONE = 1'b1;
        tick(1);
        DONE = 1'b0;
        tick(2);
        checkOutput("job1_irq", 64'(IRQ), 64'h1);
        checkOutput("job1_startcnt", 64'(startPulses), 64'd1);
        checkOutput("job1_abortcnt", 64'(abortPulses), 64'd0);
        busRead(A_STATUS, rdVal); checkOutput("job1_status", rdVal, 64'h2);
        busRead(A_RUNS, rdVal);   checkOutput("job1_runs", rdVal, 64'd1);
        busRead(A_CYCLE, rdVal);  checkOutput("job1_cycles", rdVal, 64'd10);

        // Timeout with LIMIT=4
        busWrite(A_LIMIT, 64'd4, 8'h00);
        busWrite(A_CTRL, 64'h5, 8'hFE);
        tick(10);
        checkOutput("tmo_abortcnt", 64'(abortPulses), 64'd1);
        checkOutput("tmo_startcnt", 64'(startPulses), 64'd2);
        busRead(A_STATUS, rdVal); checkOutput("tmo_status", rdVal, 64'h4);
        busRead(A_CYCLE, rdVal);  checkOutput("tmo_cycles", rdVal, 64'd3);
        checkOutput("tmo_irq", 64'(IRQ), 64'h1);

        // START while busy and ABORT in IDLE are ignored
        busWrite(A_LIMIT, 64'd0, 8'h00);
        busWrite(A_CTRL, 64'h5, 8'hFE);
        tick(2);
        busWrite(A_CTRL, 64'h5, 8'hFE);
        tick(2);
        checkOutput("busy_startcnt", 64'(startPulses), 64'd3);
        DONE = 1'b1;
        tick(1);
        DONE = 1'b0;
        tick(2);
        busRead(A_STATUS, rdVal); checkOutput("idle_status_pre", rdVal, 64'h2);
        busWrite(A_CTRL, 64'h6, 8'hFE);
        tick(3);
        checkOutput("idle_abortcnt", 64'(abortPulses), 64'd1);
        busRead(A_STATUS, rdVal); checkOutput("idle_status_post", rdVal, 64'h2);

        // START+ABORT together in IDLE behaves as START
        busWrite(A_CTRL, 64'h7, 8'hFE);
        tick(3);
        checkOutput("both_startcnt", 64'(startPulses), 64'd4);
        checkOutput("both_abortcnt", 64'(abortPulses), 64'd1);
        busRead(A_STATUS, rdVal); checkOutput("both_status", rdVal, 64'h1);
        DONE = 1'b1;
        tick(1);
        DONE = 1'b0;
        tick(2);
        busRead(A_RUNS, rdVal); checkOutput("both_runs", rdVal, 64'd3);

        // DONE and timeout in the same cycle; DONE held keeps DRAIN
        busWrite(A_LIMIT, 64'd4, 8'h00);
        busWrite(A_CTRL, 64'h5, 8'hFE);
        tick(4);
        DONE = 1'b1;
        tick(4);
        busWrite(A_CTRL, 64'h5, 8'hFE);
        tick(2);
        checkOutput("race_startcnt", 64'(startPulses), 64'd5);
        checkOutput("race_abortcnt", 64'(abortPulses), 64'd1);
        busRead(A_STATUS, rdVal); checkOutput("race_status_drain", rdVal, 64'h3);
        DONE = 1'b0;
        tick(2);
        busRead(A_STATUS, rdVal); checkOutput("race_status_idle", rdVal, 64'h2);

        // Byte-lane write to LIMIT: lanes 0 and 2 only
        busWrite(A_LIMIT, 64'h0000_0000_1122_3344, 8'hFA);
        busRead(A_LIMIT, rdVal); checkOutput("lane_limit", rdVal, 64'h0022_0044);

        // W1C colliding with DONE set: set wins, then clear
        busWrite(A_LIMIT, 64'd0, 8'h00);
        busWrite(A_CTRL, 64'h5, 8'hFE);
        tick(3);
        DONE = 1'b1;
        busWrite(A_STATUS, 64'h2, 8'hFE);
        DONE = 1'b0;
        tick(2);
        busRead(A_STATUS, rdVal); checkOutput("w1c_set_wins", rdVal, 64'h2);
        busWrite(A_STATUS, 64'h2, 8'hFE);
        busRead(A_STATUS, rdVal); checkOutput("w1c_clear", rdVal, 64'h0);
        checkOutput("w1c_irq", 64'(IRQ), 64'h0);
        busRead(A_UNMAP, rdVal);  checkOutput("unmapped_rd", rdVal, 64'h0);
        busRead(A_CTRL, rdVal);   checkOutput("ctrl_rd", rdVal, 64'h4);

        // Reset mid-RUN
        busWrite(A_CTRL, 64'h5, 8'hFE);
        tick(3);
        RESETn = 1'b0;
        tick(1);
        checkOutput("midrst_start", 64'(GCD_START), 64'h0);
        checkOutput("midrst_abort", 64'(GCD_ABORT), 64'h0);
        checkOutput("midrst_irq",   64'(IRQ), 64'h0);
        checkOutput("midrst_rdata", busIf.SRAM_RDATA, 64'h0);
        RESETn = 1'b1;
        tick(2);
        checkOutput("midrst_abortcnt", 64'(abortPulses), 64'd1);
        busRead(A_STATUS, rdVal); checkOutput("midrst_status", rdVal, 64'h0);
        busRead(A_LIMIT, rdVal);  checkOutput("midrst_limit", rdVal, 64'h0010_0000);
        busRead(A_CYCLE, rdVal);  checkOutput("midrst_cycles", rdVal, 64'h0);
        busRead(A_RUNS, rdVal);   checkOutput("midrst_runs", rdVal, 64'h0);
    endtask

    initial begin
        applyStimulus();
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/gcd_sequencer.md
GCD_SEQUENCER -- requirements
Module: gcd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_DEFAULT, 32'h0010_0000, reset value of the TIMEOUT_LIMIT register.
REQ-002 SHALL have parameter CNT_W, 32, width of the cycle counter and the timeout limit.
REQ-003 SHALL have port CLK, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port RESETn, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have SRAM_CEn/SRAM_WEn, input, 1 each, active-low chip enable and write enable.
REQ-006 SHALL have SRAM_ADDR, input, 32, byte address; only bits [5:3] are decoded.
REQ-007 SHALL have SRAM_WDATA, input, 64, write data, and SRAM_WBEn, input, 8, active-low byte enables.
REQ-008 SHALL have SRAM_RDATA, output, 64, registered read data.
REQ-009 SHALL have GCD_START, output, 1, one-cycle launch pulse to the GCD core.
REQ-010 SHALL have GCD_ABORT, output, 1, one-cycle abort pulse to the GCD core.
REQ-011 SHALL have DONE, input, 1, level completion from the GCD core.
REQ-012 SHALL have IRQ, output, 1, level interrupt.

Function
REQ-013 SHALL decode the registers by ADDR[5:3]:
- 0 CTRL: bit0 START (write-1 pulse), bit1 ABORT (write-1 pulse), bit2 IRQ_EN (RW).
- 1 STATUS: bit0 BUSY (RO), bit1 DONE_ST (W1C), bit2 TMO_ST (W1C), bit3 ABT_ST (W1C).
- 2 TIMEOUT_LIMIT: [31:0] RW; a value of 0 disables the timeout.
- 3 CYCLE_COUNT: [31:0] RO.
- 4 RUN_COUNT: [15:0] RO.
REQ-014 SHALL perform a write when CEn=0 and WEn=0, updating only byte lanes whose WBEn bit is 0.
REQ-015 SHALL perform a read when CEn=0 and WEn=1, presenting SRAM_RDATA on the next cycle and holding it until the next read.
REQ-016 SHALL return 0 for reads of unmapped addresses (5-7) and of unused bits, and SHALL ignore writes to those addresses.
REQ-017 SHALL implement the FSM states IDLE, LAUNCH, RUN and DRAIN.
REQ-018 IDLE->LAUNCH on a START write; on entry it SHALL clear CYCLE_COUNT and the DONE_ST, TMO_ST and ABT_ST bits.
REQ-019 LAUNCH SHALL assert GCD_START for exactly one cycle, then go to RUN.
REQ-020 In RUN, CYCLE_COUNT SHALL increment every cycle and saturate at all-ones.
REQ-021 RUN->DRAIN when DONE=1; this SHALL set DONE_ST and increment RUN_COUNT, which wraps modulo 2^16.
REQ-022 RUN->DRAIN when LIMIT!=0 and CYCLE_COUNT==LIMIT-1 with DONE=0; this SHALL pulse GCD_ABORT and set TMO_ST.
REQ-023 RUN->DRAIN on an ABORT write with DONE=0; this SHALL pulse GCD_ABORT and set ABT_ST.
REQ-024 DONE SHALL take priority over both timeout and ABORT in the same cycle.
REQ-025 DRAIN->IDLE when DONE=0, so that a stale DONE level never completes the next job.
REQ-026 BUSY SHALL be 1 in LAUNCH, RUN and DRAIN.
REQ-027 SHALL ignore START while BUSY, and SHALL ignore ABORT outside RUN.
REQ-028 START and ABORT written together in IDLE SHALL be treated as START only.
REQ-029 When a W1C write and a hardware set of the same status bit occur in one cycle, the set SHALL win.
REQ-030 IRQ SHALL equal IRQ_EN & (DONE_ST | TMO_ST | ABT_ST), registered, giving one cycle of latency.

Reset
REQ-031 On RESETn=0 at a clock edge, the FSM SHALL go to IDLE, even mid-job, with no abort pulse emitted.
REQ-032 Reset values SHALL be:
- GCD_START=0, GCD_ABORT=0, IRQ=0, SRAM_RDATA=0;
- all status bits 0, IRQ_EN=0;
- CYCLE_COUNT=0, RUN_COUNT=0, TIMEOUT_LIMIT=TIMEOUT_DEFAULT.

Structure
REQ-033 The register offsets, field bit positions and the FSM state enumeration SHALL reside in the shared package gcd_pkg.
REQ-034 The register file and bus decode SHALL be one sub-module, gcd_seq_regs; the FSM and counters SHALL stay in gcd_sequencer.

Verification
REQ-035 Write CTRL=0x5, DONE raised 10 cycles after GCD_START -> GCD_START is a single cycle; STATUS=0x2 after completion; IRQ=1; RUN_COUNT=1; CYCLE_COUNT=10.
REQ-036 Set LIMIT=4, START, DONE held 0 -> one GCD_ABORT pulse; TMO_ST=1; CYCLE_COUNT=3; FSM returns to IDLE.
REQ-037 Write START while BUSY, write ABORT in IDLE -> no additional GCD_START, no GCD_ABORT, STATUS unchanged.
REQ-038 DONE and the timeout expire in the same cycle -> DONE_ST=1, TMO_ST=0, no GCD_ABORT; DONE held high -> FSM stays in DRAIN and a new START is ignored.
REQ-039 Write STATUS with WBEn=0xFE, data=0x2, in the same cycle as DONE sets DONE_ST -> DONE_ST=1; a later identical write clears it; read of address 0x38 returns 0.
REQ-040 Assert RESETn=0 during RUN -> the next cycle is IDLE with all outputs at reset values and no GCD_ABORT.
